// File: rtl/serial_rx.sv
// UART receiver: 2-FF synchronised rx line, mid-bit sampling, byte output with 1-cycle strobes.
// Optional parity bit (8E1/8O1) is enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx #(
  parameter int CLK_PER_BIT = 5208,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT),
  parameter int PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_BIT = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP_BIT  = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  localparam logic [CTR_SIZE-1:0] HALF_M1 = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] FULL_M1 = CTR_SIZE'(CLK_PER_BIT - 1);

  logic                rx_m;
  logic                rx_s;
  logic [2:0]          state;
  logic [CTR_SIZE-1:0] ctr;
  logic [2:0]          bit_ctr;
  logic [7:0]          shift_q;
  logic                par_bad;

`ifdef SERIAL_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] AFTER_DAT = PARITY;

  logic par_bit;
  logic parity_err_q;

  assign par_bad    = par_bit != (^shift_q ^ (PARITY_ODD != 0));
  assign parity_err = parity_err_q;
`else
  localparam logic [2:0] AFTER_DAT = STOP_BIT;

  logic unused_cfg;

  assign unused_cfg = (PARITY_ODD != 0);
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Synchroniser: resets to the idle level so a reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctr       <= '0;
      bit_ctr   <= 3'd0;
      shift_q   <= 8'h00;
      data      <= 8'h00;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      new_data  <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START_BIT;
            ctr   <= '0;
            busy  <= 1'b1;
          end
        end
        START_BIT: begin
          if (ctr == HALF_M1) begin
            // A start bit that is high again at mid-bit was only a glitch
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              ctr     <= '0;
              bit_ctr <= 3'd0;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        DATA: begin
          if (ctr == FULL_M1) begin
            ctr              <= '0;
            shift_q[bit_ctr] <= rx_s;
            bit_ctr          <= bit_ctr + 3'd1;
            if (bit_ctr == 3'd7) state <= AFTER_DAT;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (ctr == FULL_M1) begin
            ctr     <= '0;
            par_bit <= rx_s;
            state   <= STOP_BIT;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
`endif
        STOP_BIT: begin
          if (ctr == FULL_M1) begin
            ctr <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (par_bad) begin
`ifdef SERIAL_RX_PARITY_EN
                parity_err_q <= 1'b1;
`endif
              end else begin
                data     <= shift_q;
                new_data <= 1'b1;
              end
            end else begin
              // Framing error wins over parity; stay busy until the line idles
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
